id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and execute in the 5-stage MIPS pipeline.
- Captures the decode-stage control word (RegDst, branch, Memread, MemtoReg, MemWrite, AluSrc, RegWrite, ALUop[3:0]), register operands, immediate, register specifiers and PC+4.
- Contains load-use hazard detection. It drives a stall to PC/IF-ID and inserts a bubble into EX.
- Also squashes the entry on a taken-branch flush from MEM.

Parameters:
- DATA_W, 32, width of register data, immediate and PC fields
- REG_AW, 5, register specifier width
- ALUOP_W, 4, width of the ALUop field

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- id_regdst, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  input  1 each  decode control bits
- id_aluop  input  ALUOP_W  decode ALU operation
- id_valid  input  1  decode slot holds a real instruction
- id_pc4  input  DATA_W  PC+4 of decode instruction
- id_rdata1, id_rdata2  input  DATA_W  register file read data
- id_imm  input  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  input  REG_AW  register specifiers
- flush  input  1  taken branch resolved in MEM; squash decode→EX transfer
- ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  output  1 each  registered control
- ex_aluop  output  ALUOP_W  registered ALU operation
- ex_valid  output  1  EX slot holds a real instruction
- ex_pc4, ex_rdata1, ex_rdata2, ex_imm  output  DATA_W  registered data
- ex_rs, ex_rt, ex_rd  output  REG_AW  registered specifiers
- stall  output  1  hold PC and IF/ID this cycle

Behaviour:
- Reset, synchronous and active-high: all ex_* outputs become 0 on the first rising clk with reset=1. stall then reads 0 because it derives from cleared state. Reset overrides flush and hazard.
- Hazard term, combinational from registered EX state and decode inputs only. stall = ex_valid & ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)) & id_valid.
- Update priority each rising clk, when not in reset:
  - flush=1: bubble.
  - else stall=1: bubble.
  - else load all ex_* from id_*, with ex_valid = id_valid.
- Bubble definition:
  - ex_valid and all 1-bit control outputs are cleared; ex_aluop is cleared to 0.
  - Data and specifier fields (pc4, rdata, imm, rs, rt, rd) still load from id_* but are don't-care downstream.
- Latency: one cycle decode→EX.
- A load-use stall lasts exactly one cycle. The bubble clears ex_memread, so stall deasserts the following cycle and the held instruction then advances.
- Back-to-back loads with a dependency each stall once. Independent loads never stall.
- Simultaneous flush and stall: flush wins and the entry is bubbled. stall is still asserted that cycle; upstream flush logic overrides the PC hold.
- Register 0 never creates a hazard.
- id_valid=0 is treated as a no-op: it never stalls and propagates ex_valid=0.
- Reset mid-stall clears state; no stall is asserted after reset.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_count and flush_count, each 32 bits, wrapping.
  - stall_count increments each clk where stall=1 and flush=0, excluding reset.
  - flush_count increments each clk where flush=1 and ex-bound id_valid=1.
  - Both clear on reset.
- When undefined: no counters and no extra ports. Core behaviour is identical.

Decomposition:
- Shared package (pipeline_pkg):
  - Control-word struct/constants covering the 7 control bits plus ALUop.
  - ALUop encodings ADD=4'b0000, SUB=4'b0001, RTYPE=4'b0010.
  - Opcode constants LW/SW/BEQ/RTYPE.
  - BUBBLE_CTRL all-zero constant.
- Sub-module hazard_unit: purely combinational load-use compare producing stall. Kept separate so forwarding changes do not touch the register.

Test Plan:
- Reset: hold reset=1 for 2 cycles while id_* are all ones → all ex_*=0 and stall=0. Release → the next edge loads id_*.
- Pass-through: R-type with regdst=1, regwrite=1, aluop=0010, rs=3, rt=4, rd=5, rdata1=0x10 → one clock later ex_* match and ex_valid=1.
- Load-use: LW with rt=8 in EX, then decode ADD with rs=8 → stall=1 for exactly one cycle, then EX holds a bubble (ex_valid=0, ex_regwrite=0). The ADD enters EX on the following edge with stall=0.
- Zero register and no-dependency cases:
  - LW with rt=0 in EX, decode rs=0 → stall=0.
  - LW with rt=8, decode rs=9, rt=10 → stall=0.
- Flush: flush=1 while decode holds a valid BEQ (branch=1, aluop=0001) → EX next cycle has branch=0, valid=0. With ID_EX_PERF_CNT_EN defined, flush_count=1.
- Flush and stall together: LW rt=8 in EX, decode rs=8, flush=1 → bubble inserted. Next cycle stall=0 and decode content is accepted normally.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: the decode control word, ALU operation encodings and opcodes.
package pipeline_pkg;

  localparam int CTRL_ALUOP_W = 4;

  typedef struct packed {
    logic regdst;
    logic branch;
    logic memread;
    logic memtoreg;
    logic memwrite;
    logic alusrc;
    logic regwrite;
  } ctrl_t;

  typedef struct packed {
    ctrl_t                   bits;
    logic [CTRL_ALUOP_W-1:0] aluop;
  } ctrl_word_t;

  localparam ctrl_t      BUBBLE_CTRL = '0;
  localparam ctrl_word_t BUBBLE_WORD = '0;

  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ADD   = 4'b0000;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_SUB   = 4'b0001;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_RTYPE = 4'b0010;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector: compares the load sitting in EX against the decode source registers.
module hazard_unit #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  output logic              stall_o
);

  logic rtNonZero;
  logic rtMatch;

  // Register 0 is hardwired, so a load targeting it can never feed a dependent instruction.
  assign rtNonZero = (ex_rt_i != '0);
  assign rtMatch   = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);
  assign stall_o   = ex_valid_i && ex_memread_i && rtNonZero && rtMatch && id_valid_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch-flush bubble insertion.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_regdst,
  input  logic               id_branch,
  input  logic               id_memread,
  input  logic               id_memtoreg,
  input  logic               id_memwrite,
  input  logic               id_alusrc,
  input  logic               id_regwrite,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc4,
  input  logic [DATA_W-1:0]  id_rdata1,
  input  logic [DATA_W-1:0]  id_rdata2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               flush,
  output logic               ex_regdst,
  output logic               ex_branch,
  output logic               ex_memread,
  output logic               ex_memtoreg,
  output logic               ex_memwrite,
  output logic               ex_alusrc,
  output logic               ex_regwrite,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_pc4,
  output logic [DATA_W-1:0]  ex_rdata1,
  output logic [DATA_W-1:0]  ex_rdata2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]        stall_count,
  output logic [31:0]        flush_count
`endif
);

  ctrl_t               ctrl_d, ctrl_q;
  logic [ALUOP_W-1:0]  aluop_d, aluop_q;
  logic                valid_d, valid_q;
  logic [DATA_W-1:0]   pc4_q, rdata1_q, rdata2_q, imm_q;
  logic [REG_AW-1:0]   rs_q, rt_q, rd_q;

  hazard_unit #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_valid_i   (valid_q),
    .ex_memread_i (ctrl_q.memread),
    .ex_rt_i      (rt_q),
    .id_valid_i   (id_valid),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .stall_o      (stall)
  );

  // Flush and stall both turn the EX slot into a bubble; only control and valid are cleared.
  always_comb begin
    ctrl_d  = '{regdst:   id_regdst,
                branch:   id_branch,
                memread:  id_memread,
                memtoreg: id_memtoreg,
                memwrite: id_memwrite,
                alusrc:   id_alusrc,
                regwrite: id_regwrite};
    aluop_d = id_aluop;
    valid_d = id_valid;
    if (flush || stall) begin
      ctrl_d  = BUBBLE_CTRL;
      aluop_d = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= BUBBLE_CTRL;
      aluop_q  <= '0;
      valid_q  <= 1'b0;
      pc4_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      aluop_q  <= aluop_d;
      valid_q  <= valid_d;
      pc4_q    <= id_pc4;
      rdata1_q <= id_rdata1;
      rdata2_q <= id_rdata2;
      imm_q    <= id_imm;
      rs_q     <= id_rs;
      rt_q     <= id_rt;
      rd_q     <= id_rd;
    end
  end

  assign ex_regdst   = ctrl_q.regdst;
  assign ex_branch   = ctrl_q.branch;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_aluop    = aluop_q;
  assign ex_valid    = valid_q;
  assign ex_pc4      = pc4_q;
  assign ex_rdata1   = rdata1_q;
  assign ex_rdata2   = rdata2_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stallCnt_q, flushCnt_q;

  // A stall overridden by flush is not a real PC hold, so it is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (stall && !flush)
        stallCnt_q <= stallCnt_q + 32'd1;
      if (flush && id_valid)
        flushCnt_q <= flushCnt_q + 32'd1;
    end
  end

  assign stall_count = stallCnt_q;
  assign flush_count = flushCnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a behavioural EX-slot model compared every cycle plus directed literal checks.
// Define ID_EX_PERF_CNT_EN to also check the performance counters.
module tb_id_ex_stage;

  logic        clock;
  logic        reset;
  logic        idRegdst, idBranch, idMemread, idMemtoreg, idMemwrite, idAlusrc, idRegwrite;
  logic [3:0]  idAluop;
  logic        idValid;
  logic [31:0] idPc4, idRdata1, idRdata2, idImm;
  logic [4:0]  idRs, idRt, idRd;
  logic        flush;
  logic        exRegdst, exBranch, exMemread, exMemtoreg, exMemwrite, exAlusrc, exRegwrite;
  logic [3:0]  exAluop;
  logic        exValid;
  logic [31:0] exPc4, exRdata1, exRdata2, exImm;
  logic [4:0]  exRs, exRt, exRd;
  logic        stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stallCount, flushCount;
`endif

  int checks = 0;
  int errors = 0;

  // Control bit order used throughout the bench: {regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite}.
  localparam logic [6:0] C_RTYPE = 7'b1000001;
  localparam logic [6:0] C_LW    = 7'b0011011;
  localparam logic [6:0] C_BEQ   = 7'b0100000;

  typedef enum int {PH_RESET, PH_RUN} phase_e;
  phase_e phase;

  id_ex_stage dut (
    .clk         (clock),
    .reset       (reset),
    .id_regdst   (idRegdst),
    .id_branch   (idBranch),
    .id_memread  (idMemread),
    .id_memtoreg (idMemtoreg),
    .id_memwrite (idMemwrite),
    .id_alusrc   (idAlusrc),
    .id_regwrite (idRegwrite),
    .id_aluop    (idAluop),
    .id_valid    (idValid),
    .id_pc4      (idPc4),
    .id_rdata1   (idRdata1),
    .id_rdata2   (idRdata2),
    .id_imm      (idImm),
    .id_rs       (idRs),
    .id_rt       (idRt),
    .id_rd       (idRd),
    .flush       (flush),
    .ex_regdst   (exRegdst),
    .ex_branch   (exBranch),
    .ex_memread  (exMemread),
    .ex_memtoreg (exMemtoreg),
    .ex_memwrite (exMemwrite),
    .ex_alusrc   (exAlusrc),
    .ex_regwrite (exRegwrite),
    .ex_aluop    (exAluop),
    .ex_valid    (exValid),
    .ex_pc4      (exPc4),
    .ex_rdata1   (exRdata1),
    .ex_rdata2   (exRdata2),
    .ex_imm      (exImm),
    .ex_rs       (exRs),
    .ex_rt       (exRt),
    .ex_rd       (exRd),
    .stall       (stall)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .stall_count (stallCount),
    .flush_count (flushCount)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural model of the EX slot: what the decode->EX transfer must hold after each edge.
  logic        mValid;
  logic [6:0]  mCtrl;
  logic [3:0]  mAluop;
  logic [31:0] mPc4, mR1, mR2, mImm;
  logic [4:0]  mRs, mRt, mRd;
  logic [31:0] mStallCnt, mFlushCnt;

  initial begin
    mValid = 0; mCtrl = 0; mAluop = 0; mPc4 = 0; mR1 = 0; mR2 = 0; mImm = 0;
    mRs = 0; mRt = 0; mRd = 0; mStallCnt = 0; mFlushCnt = 0;
  end

  // A load in EX blocks a valid decode instruction that reads its destination, unless that is r0.
  function automatic logic modelStall();
    logic isLoad;
    logic reads;
    isLoad = mValid && mCtrl[4] && (mRt != 5'd0);
    reads  = (mRt == idRs) || (mRt == idRt);
    return isLoad && reads && idValid;
  endfunction

  always @(posedge clock) begin
    logic st;
    st = modelStall();
    if (reset) begin
      mValid = 0; mCtrl = 0; mAluop = 0; mPc4 = 0; mR1 = 0; mR2 = 0; mImm = 0;
      mRs = 0; mRt = 0; mRd = 0; mStallCnt = 0; mFlushCnt = 0;
    end else begin
      if (st && !flush) mStallCnt = mStallCnt + 1;
      if (flush && idValid) mFlushCnt = mFlushCnt + 1;
      if (flush || st) begin
        mValid = 0; mCtrl = 0; mAluop = 0;
      end else begin
        mValid = idValid;
        mCtrl  = {idRegdst, idBranch, idMemread, idMemtoreg, idMemwrite, idAlusrc, idRegwrite};
        mAluop = idAluop;
      end
      mPc4 = idPc4; mR1 = idRdata1; mR2 = idRdata2; mImm = idImm;
      mRs = idRs; mRt = idRt; mRd = idRd;
    end
  end

  // Every cycle, on the falling edge, compare the DUT against the model.
  always @(negedge clock) begin
    logic [11:0]  actCtl, expCtl;
    logic [142:0] actDat, expDat;
    logic         expSt;
    actCtl = {exValid, exRegdst, exBranch, exMemread, exMemtoreg, exMemwrite, exAlusrc, exRegwrite, exAluop};
    expCtl = {mValid, mCtrl, mAluop};
    actDat = {exPc4, exRdata1, exRdata2, exImm, exRs, exRt, exRd};
    expDat = {mPc4, mR1, mR2, mImm, mRs, mRt, mRd};
    expSt  = modelStall();
    checks++;
    if (actCtl !== expCtl) begin
      errors++;
      $display("[TB] FAIL model_ctrl t=%0t actual=%h expected=%h", $time, actCtl, expCtl);
    end
    checks++;
    if (actDat !== expDat) begin
      errors++;
      $display("[TB] FAIL model_data t=%0t actual=%h expected=%h", $time, actDat, expDat);
    end
    checks++;
    if (stall !== expSt) begin
      errors++;
      $display("[TB] FAIL model_stall t=%0t actual=%b expected=%b", $time, stall, expSt);
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if ({stallCount, flushCount} !== {mStallCnt, mFlushCnt}) begin
      errors++;
      $display("[TB] FAIL model_counters t=%0t actual=%0d/%0d expected=%0d/%0d",
               $time, stallCount, flushCount, mStallCnt, mFlushCnt);
    end
`endif
  end

  task automatic applyStimulus(input logic v, input logic [6:0] c, input logic [3:0] op,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [31:0] r1, input logic fl);
    idValid = v;
    {idRegdst, idBranch, idMemread, idMemtoreg, idMemwrite, idAlusrc, idRegwrite} = c;
    idAluop  = op;
    idRs     = rs;
    idRt     = rt;
    idRd     = rd;
    idRdata1 = r1;
    idRdata2 = ~r1;
    idImm    = r1 + 32'h100;
    idPc4    = {r1[27:0], 4'h4};
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  initial begin
    phase = PH_RESET;
    reset = 1'b1;
    applyStimulus(1'b1, 7'h7f, 4'hf, 5'h1f, 5'h1f, 5'h1f, 32'hffff_ffff, 1'b0);
    idRdata2 = '1; idImm = '1; idPc4 = '1;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    checkOutput("reset_valid", exValid, 0);
    checkOutput("reset_ctrl", {exRegdst, exBranch, exMemread, exMemtoreg, exMemwrite, exAlusrc, exRegwrite, exAluop}, 0);
    checkOutput("reset_data", {exPc4, exRdata1, exRd}, 0);
    checkOutput("reset_stall", stall, 0);
    reset = 1'b0;
    phase = PH_RUN;
    tick();
    checkOutput("release_load_valid", exValid, 1);
    checkOutput("release_load_pc4", exPc4, 64'hffff_ffff);
    checkOutput("release_load_aluop", exAluop, 4'hf);
    checkOutput("release_stall", stall, 1);

    // R-type pass-through
    applyStimulus(1'b1, C_RTYPE, 4'b0010, 5'd3, 5'd4, 5'd5, 32'h10, 1'b0);
    tick();
    checkOutput("rtype_valid", exValid, 1);
    checkOutput("rtype_ctrl", {exRegdst, exRegwrite, exMemread, exAluop}, {3'b110, 4'b0010});
    checkOutput("rtype_regs", {exRs, exRt, exRd, exRdata1}, {5'd3, 5'd4, 5'd5, 32'h10});

    // Load-use: one-cycle stall, bubble, then the held ADD advances
    applyStimulus(1'b1, C_LW, 4'b0000, 5'd2, 5'd8, 5'd0, 32'h20, 1'b0);
    tick();
    applyStimulus(1'b1, C_RTYPE, 4'b0000, 5'd8, 5'd9, 5'd10, 32'h30, 1'b0);
    #1;
    checkOutput("loaduse_stall", stall, 1);
    tick();
    checkOutput("loaduse_bubble", {exValid, exRegwrite}, 0);
    checkOutput("loaduse_stall_clears", stall, 0);
    tick();
    checkOutput("loaduse_advance", {exValid, exRegwrite, exRs, exRd}, {2'b11, 5'd8, 5'd10});
    checkOutput("loaduse_after_stall", stall, 0);

    // Load into r0 never stalls
    applyStimulus(1'b1, C_LW, 4'b0000, 5'd2, 5'd0, 5'd0, 32'h40, 1'b0);
    tick();
    applyStimulus(1'b1, C_RTYPE, 4'b0000, 5'd0, 5'd0, 5'd11, 32'h50, 1'b0);
    #1;
    checkOutput("zero_reg_stall", stall, 0);
    tick();

    // Independent load never stalls
    applyStimulus(1'b1, C_LW, 4'b0000, 5'd2, 5'd8, 5'd0, 32'h60, 1'b0);
    tick();
    applyStimulus(1'b1, C_RTYPE, 4'b0000, 5'd9, 5'd10, 5'd12, 32'h70, 1'b0);
    #1;
    checkOutput("nodep_stall", stall, 0);
    tick();
    checkOutput("nodep_advance", {exValid, exRd}, {1'b1, 5'd12});

    // Flush squashes a valid BEQ
    applyStimulus(1'b1, C_BEQ, 4'b0001, 5'd1, 5'd2, 5'd0, 32'h80, 1'b1);
    tick();
    checkOutput("flush_bubble", {exValid, exBranch, exAluop}, 0);
`ifdef ID_EX_PERF_CNT_EN
    checkOutput("flush_count_one", flushCount, 1);
    checkOutput("stall_count_one", stallCount, 1);
`endif

    // Flush and stall together: flush wins, then decode is accepted
    applyStimulus(1'b1, C_LW, 4'b0000, 5'd2, 5'd8, 5'd0, 32'h90, 1'b0);
    tick();
    applyStimulus(1'b1, C_RTYPE, 4'b0000, 5'd8, 5'd3, 5'd13, 32'ha0, 1'b1);
    #1;
    checkOutput("flushstall_stall", stall, 1);
    tick();
    checkOutput("flushstall_bubble", exValid, 0);
    checkOutput("flushstall_stall_clears", stall, 0);
    flush = 1'b0;
    tick();
    checkOutput("flushstall_accept", {exValid, exRd}, {1'b1, 5'd13});

    // Invalid decode slot is a no-op
    applyStimulus(1'b1, C_LW, 4'b0000, 5'd2, 5'd8, 5'd0, 32'hb0, 1'b0);
    tick();
    applyStimulus(1'b0, C_RTYPE, 4'b0000, 5'd8, 5'd8, 5'd14, 32'hc0, 1'b0);
    #1;
    checkOutput("invalid_stall", stall, 0);
    tick();
    checkOutput("invalid_propagates", exValid, 0);

    // Reset in the middle of a stall
    applyStimulus(1'b1, C_LW, 4'b0000, 5'd2, 5'd8, 5'd0, 32'hd0, 1'b0);
    tick();
    applyStimulus(1'b1, C_RTYPE, 4'b0000, 5'd8, 5'd3, 5'd15, 32'he0, 1'b0);
    #1;
    checkOutput("midstall_stall", stall, 1);
    reset = 1'b1;
    tick();
    checkOutput("midstall_reset_state", {exValid, exMemread, exRt}, 0);
    checkOutput("midstall_reset_stall", stall, 0);
`ifdef ID_EX_PERF_CNT_EN
    checkOutput("midstall_reset_counters", {stallCount, flushCount}, 0);
`endif
    reset = 1'b0;
    tick();
    checkOutput("post_reset_accept", {exValid, exRd}, {1'b1, 5'd15});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
